// File: rtl/shift_pipe_arbiter.sv
// Round-robin arbiter that feeds one shared DEPTH-stage shift pipeline and tags each word with its requester ID.
// Latency: a word granted at edge t reaches the tail after edge t+DEPTH-1; each stall cycle adds one cycle.
// Backpressure: the whole pipe stalls when the tail is valid and out_ready is low, and no grant is issued then.
module shift_pipe_arbiter #(
    parameter int DW    = 8,
    parameter int DEPTH = 3,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [IDW-1:0]       out_id,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [4:0]           occ
);

    logic [DEPTH:1]  vld;
    logic [DW-1:0]   dat [1:DEPTH];
    logic [IDW-1:0]  id  [1:DEPTH];
    logic [IDW-1:0]  rr_ptr;
    logic [4:0]      occ_q;

    logic            adv;
    logic            found;
    logic            grant;
    logic            consume;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  ptr_nxt;
    logic [DW-1:0]   win_dat;

    // The pipe moves whenever the tail is empty or being taken.
    assign adv     = !vld[DEPTH] || out_ready;
    assign grant   = found && adv && !flush && rst_n;
    assign consume = vld[DEPTH] && out_ready;
    assign ptr_nxt = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

    // Scan requesters starting at rr_ptr, wrapping at NREQ; first hit wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = int'(rr_ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                win   = IDW'(j);
            end
        end
    end

    // Mux the winner's data word out of the flat request bus.
    always_comb begin
        win_dat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win) win_dat = req_data[i*DW +: DW];
        end
    end

    // One-hot grant, only when the word can actually enter stage 1.
    always_comb begin
        gnt = '0;
        if (grant) gnt = NREQ'(1) << win;
    end

    // Shift pipeline, round-robin pointer and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld    <= '0;
            rr_ptr <= '0;
            occ_q  <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                dat[k] <= '0;
                id[k]  <= '0;
            end
        end else if (flush) begin
            // Only valid bits are dropped; payload and rotation survive.
            vld   <= '0;
            occ_q <= '0;
        end else if (adv) begin
            vld[1] <= grant;
            dat[1] <= grant ? win_dat : '0;
            id[1]  <= grant ? win : '0;
            for (int k = 2; k <= DEPTH; k++) begin
                vld[k] <= vld[k-1];
                dat[k] <= dat[k-1];
                id[k]  <= id[k-1];
            end
            if (grant) rr_ptr <= ptr_nxt;
            if (grant && !consume)      occ_q <= occ_q + 5'd1;
            else if (!grant && consume) occ_q <= occ_q - 5'd1;
        end
    end

    assign out_valid = vld[DEPTH];
    assign out_data  = dat[DEPTH];
    assign out_id    = id[DEPTH];
    assign busy      = |vld;
    assign occ       = occ_q;

endmodule
